// File: rtl/enoc_core_injector_pkg.sv
// Shared ENoC configuration: node-index width, payload width, packet layout
// and node-id helper used by all mesh endpoints.
package enoc_core_injector_pkg;

  localparam int ENOC_NODE_W = 8;
  localparam int ENOC_DATA_W = 32;
  localparam int ENOC_MAX_NODES = 1 << ENOC_NODE_W;

  typedef logic [ENOC_NODE_W-1:0] node_idx_t;

  typedef struct packed {
    logic                   valid;
    node_idx_t              source;
    node_idx_t              dest;
    logic [ENOC_DATA_W-1:0] data;
  } packet_t;

  // Row-major node numbering across the mesh.
  function automatic node_idx_t enoc_node_id(input int x, input int y, input int x_nodes);
    return node_idx_t'(y * x_nodes + x);
  endfunction

endpackage

// File: rtl/enoc_inj_fifo.sv
// Injection queue storage: DEPTH-entry circular buffer, head visible combinationally
// from registered storage. Caller guarantees no write when full and no read when empty.
module enoc_inj_fifo
  import enoc_core_injector_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  packet_t                  wr_data,
  input  logic                     rd_en,
  output packet_t                  rd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  packet_t          mem [DEPTH];

  // Pointers wrap for free because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/enoc_core_injector.sv
// Core-to-router injection port: stamps source, drops bad destinations, queues packets.
// Optional statistics counters are built when ENOC_INJ_STATS_EN is defined.
module enoc_core_injector
  import enoc_core_injector_pkg::*;
#(
  parameter int X_NODES = 4,
  parameter int Y_NODES = 4,
  parameter int X_LOC   = 0,
  parameter int Y_LOC   = 0,
  parameter int DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  packet_t     i_pkt,
  input  logic        i_pkt_val,
  output logic        o_pkt_en,
  output packet_t     o_data,
  output logic        o_data_val,
  input  logic        i_en,
`ifdef ENOC_INJ_STATS_EN
  output logic [31:0] o_inj_count,
  output logic [15:0] o_drop_count,
  output logic [31:0] o_stall_count,
`endif
  output logic        o_drop
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam node_idx_t SRC_ID = enoc_node_id(X_LOC, Y_LOC, X_NODES);
  localparam logic [ENOC_NODE_W:0] NODE_CNT = (ENOC_NODE_W + 1)'(X_NODES * Y_NODES);

  logic [CNT_W-1:0] count;
  packet_t          head;
  packet_t          wr_pkt;
  logic             push;
  logic             pop;
  logic             bad_dest;
  logic             wr_en;

  // Flow control looks only at registered occupancy so the core never sees i_en.
  assign o_pkt_en   = (count < CNT_W'(DEPTH));
  assign o_data_val = (count != '0);

  assign push     = i_pkt_val && o_pkt_en;
  assign pop      = o_data_val && i_en;
  assign bad_dest = ({1'b0, i_pkt.dest} >= NODE_CNT);
  assign wr_en    = push && !bad_dest;

  always_comb begin
    wr_pkt        = i_pkt;
    wr_pkt.source = SRC_ID;
    wr_pkt.valid  = 1'b1;
  end

  always_comb begin
    o_data       = head;
    o_data.valid = o_data_val;
  end

  enoc_inj_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (wr_en),
    .wr_data (wr_pkt),
    .rd_en   (pop),
    .rd_data (head),
    .count   (count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) o_drop <= 1'b0;
    else          o_drop <= push && bad_dest;
  end

`ifdef ENOC_INJ_STATS_EN
  // All counters stick at their maximum rather than wrapping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_inj_count   <= '0;
      o_drop_count  <= '0;
      o_stall_count <= '0;
    end else begin
      if (pop && (o_inj_count != '1))
        o_inj_count <= o_inj_count + 1'b1;
      if (push && bad_dest && (o_drop_count != '1))
        o_drop_count <= o_drop_count + 1'b1;
      if (o_data_val && !i_en && (o_stall_count != '1))
        o_stall_count <= o_stall_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_enoc_core_injector.sv
// Scoreboard bench for enoc_core_injector on a 4x4 mesh at node (1,2), DEPTH 4.
module tb_enoc_core_injector;
  import enoc_core_injector_pkg::*;

  localparam int XN = 4, YN = 4, XL = 1, YL = 2, DEP = 4;
  localparam logic [7:0] SRC = 8'd9;

  logic    clk = 1'b0;
  logic    reset_n;
  packet_t i_pkt;
  logic    i_pkt_val;
  logic    o_pkt_en;
  packet_t o_data;
  logic    o_data_val;
  logic    i_en;
  logic    o_drop;
`ifdef ENOC_INJ_STATS_EN
  logic [31:0] o_inj_count;
  logic [15:0] o_drop_count;
  logic [31:0] o_stall_count;
`endif

  int checks = 0;
  int errors = 0;
  packet_t exp_q[$];

  always #5 clk = ~clk;

  enoc_core_injector #(
    .X_NODES(XN), .Y_NODES(YN), .X_LOC(XL), .Y_LOC(YL), .DEPTH(DEP)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_pkt      (i_pkt),
    .i_pkt_val  (i_pkt_val),
    .o_pkt_en   (o_pkt_en),
    .o_data     (o_data),
    .o_data_val (o_data_val),
    .i_en       (i_en),
`ifdef ENOC_INJ_STATS_EN
    .o_inj_count   (o_inj_count),
    .o_drop_count  (o_drop_count),
    .o_stall_count (o_stall_count),
`endif
    .o_drop     (o_drop)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic packet_t mk_in(input logic [7:0] dest, input logic [31:0] data);
    packet_t p;
    p.valid = 1'b0; p.source = 8'hAA; p.dest = dest; p.data = data;
    return p;
  endfunction

  function automatic packet_t mk_exp(input logic [7:0] dest, input logic [31:0] data);
    packet_t p;
    p.valid = 1'b1; p.source = SRC; p.dest = dest; p.data = data;
    return p;
  endfunction

  // Monitor: every pop the DUT performs must match the scoreboard head.
  always @(negedge clk) begin
    if (reset_n && o_data_val && i_en) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_pop: got data %0h with empty scoreboard", o_data.data);
      end else begin
        check("pop_packet", 64'(o_data), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [7:0] dest, input logic [31:0] data);
    int n = 0;
    while (!o_pkt_en && n < 20) begin tick(); n++; end
    check("send_pkt_en", 64'(o_pkt_en), 64'(1));
    i_pkt = mk_in(dest, data);
    i_pkt_val = 1'b1;
    if (dest < 8'd16) exp_q.push_back(mk_exp(dest, data));
    tick();
    i_pkt_val = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    i_en = 1'b1;
    while (o_data_val && n < 20) begin tick(); n++; end
    check("drain_empty", 64'(o_data_val), 64'(0));
    i_en = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; i_pkt = '0; i_pkt_val = 1'b0; i_en = 1'b0;
    tick(); tick();
    check("rst_data_val", 64'(o_data_val), 64'(0));
    check("rst_pkt_en",   64'(o_pkt_en),   64'(1));
    check("rst_drop",     64'(o_drop),     64'(0));

    // First push lands on the first rising edge after release.
    i_en = 1'b1;
    i_pkt = mk_in(8'd5, 32'd1); i_pkt_val = 1'b1;
    exp_q.push_back(mk_exp(8'd5, 32'd1));
    reset_n = 1'b1;
    tick();
    i_pkt_val = 1'b0;
    check("first_push_val", 64'(o_data_val), 64'(1));
    check("first_push_src", 64'(o_data.source), 64'(SRC));
    send(8'd5, 32'd2);
    send(8'd5, 32'd3);
    drain();

    // Fill with i_en low, hold a fifth, then release.
    for (int i = 0; i < 4; i++) send(8'd7, 32'd10 + 32'(i));
    check("full_pkt_en", 64'(o_pkt_en), 64'(0));
    i_pkt = mk_in(8'd7, 32'd14); i_pkt_val = 1'b1;
    exp_q.push_back(mk_exp(8'd7, 32'd14));
    tick(); tick();
    check("held_pkt_en", 64'(o_pkt_en), 64'(0));
    check("stable_head", 64'(o_data.data), 64'(10));
    i_en = 1'b1;
    tick();
    check("pkt_en_after_pop", 64'(o_pkt_en), 64'(1));
    tick();
    i_pkt_val = 1'b0;
    drain();

    // Destination range check.
    send(8'd16, 32'hBAD);
    check("drop_pulse", 64'(o_drop), 64'(1));
    check("drop_no_write", 64'(o_data_val), 64'(0));
    tick();
    check("drop_one_cycle", 64'(o_drop), 64'(0));
    send(8'd15, 32'h77);
    check("dest15_ok", 64'(o_data_val), 64'(1));
    check("dest15_nodrop", 64'(o_drop), 64'(0));
    send(8'd200, 32'hBAD2);
    check("drop2_pulse", 64'(o_drop), 64'(1));
    check("drop2_head", 64'(o_data.data), 64'(32'h77));
    drain();

    // Occupancy 3 with concurrent push/pop; pointers wrap.
    for (int i = 0; i < 3; i++) send(8'd3, 32'd100 + 32'(i));
    i_en = 1'b1;
    for (int i = 0; i < 6; i++) send(8'd3, 32'd103 + 32'(i));
    i_en = 1'b0;
    check("occ3_pkt_en", 64'(o_pkt_en), 64'(1));
    send(8'd3, 32'd109);
    check("occ4_pkt_en", 64'(o_pkt_en), 64'(0));
    drain();

    // Reset mid-stream.
    send(8'd2, 32'd201);
    send(8'd2, 32'd202);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_val", 64'(o_data_val), 64'(0));
    check("midrst_pkt_en", 64'(o_pkt_en), 64'(1));
    exp_q.delete();
    tick();
    reset_n = 1'b1;
    i_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_rst_idle", 64'(o_data_val), 64'(0));
    end
    send(8'd4, 32'd300);
    drain();

    // Counters, from a fresh reset.
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    send(8'd1, 32'd400);
    repeat (10) tick();
    i_en = 1'b1;
    tick();
    i_en = 1'b0;
    send(8'd16, 32'hBAD3);
`ifdef ENOC_INJ_STATS_EN
    check("stall_count", 64'(o_stall_count), 64'(10));
    check("inj_count",   64'(o_inj_count),   64'(1));
    check("drop_count",  64'(o_drop_count),  64'(1));
`endif
    check("stats_empty", 64'(o_data_val), 64'(0));

    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
